keypad_scanner: RTL and testbench

- Upstream stage of the dual seven-segment display path.
- Scans a 4x4 active-low matrix keypad and debounces presses and releases.
- Emits one event per physical key press.
- Maintains the two most recent hex digits (digit_new, digit_old); the display multiplexer and the segment decoder consume these as the right and left digits.

---
 rtl/keypad_scanner.sv | 176 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debouncing.
// Emits one key_valid pulse per accepted press and keeps the last two hex digits.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    sync1_reg, rows_s_reg;
    logic [1:0]    col_reg, col_next;
    logic [1:0]    row_reg, row_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          key_valid_reg, key_valid_next;
    logic [3:0]    key_code_reg, key_code_next;
    logic [3:0]    digit_new_reg, digit_new_next;
    logic [3:0]    digit_old_reg, digit_old_next;

    logic [1:0]    low_row;
    logic          any_low;
    logic          row_low;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;
            4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;
            4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;
            4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;
            4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;
            4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;
            4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;
            4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign cols[gi] = (col_reg != 2'(gi));
        end
    endgenerate

    // Lowest-index low row wins when several rows of the column are pressed.
    always_comb begin
        low_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows_s_reg[r]) low_row = 2'(r);
        end
    end

    assign any_low = (rows_s_reg != 4'hF);
    assign row_low = !rows_s_reg[row_reg];

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        dwell_next     = dwell_reg;
        cnt_next       = cnt_reg;
        key_valid_next = 1'b0;
        key_code_next  = key_code_reg;
        digit_new_next = digit_new_reg;
        digit_old_next = digit_old_reg;
        case (state_reg)
            SCAN: begin
                if (dwell_reg == DWELL_LAST) begin
                    dwell_next = '0;
                    if (any_low) begin
                        row_next   = low_row;
                        cnt_next   = '0;
                        state_next = DEBOUNCE;
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end else begin
                    dwell_next = dwell_reg + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_low) begin
                    state_next = SCAN;
                    col_next   = col_reg + 2'd1;
                    dwell_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next       = cnt_reg + 1'b1;
                    state_next     = HELD;
                    key_valid_next = 1'b1;
                    key_code_next  = key_map(row_reg, col_reg);
                    digit_new_next = key_map(row_reg, col_reg);
                    digit_old_next = digit_new_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!row_low) begin
                    cnt_next   = '0;
                    state_next = RELEASE;
                end
            end
            default: begin
                if (row_low) begin
                    state_next = HELD;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = SCAN;
                    col_next   = col_reg + 2'd1;
                    dwell_next = '0;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg     <= 4'hF;
            rows_s_reg    <= 4'hF;
            state_reg     <= SCAN;
            col_reg       <= 2'd0;
            row_reg       <= 2'd0;
            dwell_reg     <= '0;
            cnt_reg       <= '0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'h0;
            digit_new_reg <= 4'h0;
            digit_old_reg <= 4'h0;
        end else begin
            sync1_reg     <= rows;
            rows_s_reg    <= sync1_reg;
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            dwell_reg     <= dwell_next;
            cnt_reg       <= cnt_next;
            key_valid_reg <= key_valid_next;
            key_code_reg  <= key_code_next;
            digit_new_reg <= digit_new_next;
            digit_old_reg <= digit_old_next;
        end
    end

    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign digit_new = digit_new_reg;
    assign digit_old = digit_old_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from cols, and
// a digit-history model predicts key_code/digit_new/digit_old for every accept.
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    int checks = 0;
    int failures = 0;
    int ev_count = 0;
    int cyc = 0;

    logic [15:0] pressed = 16'h0;
    logic [3:0]  exp_code = 4'h0;
    logic [3:0]  m_new = 4'h0, m_old = 4'h0;
    logic        prev_kv = 1'b0;
    logic [3:0]  prev_code = 4'h0, prev_new = 4'h0, prev_old = 4'h0;

    // Keypad legend indexed by row*4 + column.
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .key_valid(key_valid), .key_code(key_code),
        .digit_new(digit_new), .digit_old(digit_old)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    // Advance one cycle and watch the output invariants and the digit model.
    task automatic step();
        logic rs;
        rs = reset;
        @(negedge clk);
        cyc++;
        checks++;
        if ($countones(cols) != 3) begin
            failures++;
            $display("FAIL cols_onehot cyc=%0d actual=%b", cyc, cols);
        end
        if (rs) begin
            m_new = 4'h0;
            m_old = 4'h0;
            checks++;
            if ({key_valid, key_code, digit_new, digit_old} !== 13'h0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d kv=%b code=%h new=%h old=%h required all 0",
                         cyc, key_valid, key_code, digit_new, digit_old);
            end
        end else if (key_valid) begin
            ev_count++;
            m_old = m_new;
            m_new = exp_code;
            $display("EVENT cyc=%0d key_code=%h digit_new=%h digit_old=%h", cyc, key_code, digit_new, digit_old);
            checks++;
            if (prev_kv) begin
                failures++;
                $display("FAIL kv_double cyc=%0d key_valid high two cycles", cyc);
            end
            checks++;
            if (key_code !== exp_code || digit_new !== m_new || digit_old !== m_old) begin
                failures++;
                $display("FAIL accept_values cyc=%0d actual code=%h new=%h old=%h required code=%h new=%h old=%h",
                         cyc, key_code, digit_new, digit_old, exp_code, m_new, m_old);
            end
        end else begin
            checks++;
            if (key_code !== prev_code || digit_new !== prev_new || digit_old !== prev_old) begin
                failures++;
                $display("FAIL outputs_hold cyc=%0d actual code=%h new=%h old=%h required code=%h new=%h old=%h",
                         cyc, key_code, digit_new, digit_old, prev_code, prev_new, prev_old);
            end
        end
        prev_kv   = key_valid;
        prev_code = key_code;
        prev_new  = digit_new;
        prev_old  = digit_old;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_event(input int start, input int budget, input string name);
        int i;
        for (i = 0; i < budget && ev_count == start; i++) step();
        checks++;
        if (ev_count == start) begin
            failures++;
            $display("FAIL %s_timeout no key_valid within %0d cycles", name, budget);
        end
    endtask

    // After a release, cols must stay on column c for 8 cycles, then move to c+1.
    task automatic check_release_resume(input int c, input string name);
        logic [3:0] held_cols, next_cols;
        int i;
        held_cols = ~(4'b0001 << c);
        next_cols = ~(4'b0001 << ((c + 1) % 4));
        for (i = 0; i < 8; i++) begin
            step();
            checks++;
            if (cols !== held_cols) begin
                failures++;
                $display("FAIL %s_cols_frozen i=%0d actual=%b required=%b", name, i, cols, held_cols);
            end
        end
        for (i = 0; i < 20 && cols === held_cols; i++) step();
        checks++;
        if (cols !== next_cols) begin
            failures++;
            $display("FAIL %s_resume actual=%b required=%b", name, cols, next_cols);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        steps(2);
        checks++;
        if (cols !== 4'b1110) begin
            failures++;
            $display("FAIL reset_cols actual=%b required=1110", cols);
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] want;
            want = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (cols !== want) begin
                failures++;
                $display("FAIL scan_order k=%0d actual=%b required=%b", k, cols, want);
            end
            step();
        end
    endtask

    task automatic test_single();
        int start, t;
        start = ev_count;
        exp_code = keymap[1*4+1];
        pressed = 16'h0;
        pressed[1*4+1] = 1'b1;
        for (t = 0; t < 40 && ev_count == start; t++) step();
        checks++;
        if (ev_count != start + 1) begin
            failures++;
            $display("FAIL single_accept events=%0d required=1", ev_count - start);
        end
        for (; t < 40; t++) begin
            step();
            checks++;
            if (cols !== 4'b1101) begin
                failures++;
                $display("FAIL single_held_cols actual=%b required=1101", cols);
            end
        end
        pressed = 16'h0;
        check_release_resume(1, "single");
        steps(10);
        checks++;
        if (ev_count != start + 1 || key_code !== 4'h5 || digit_new !== 4'h5 || digit_old !== 4'h0) begin
            failures++;
            $display("FAIL single_final events=%0d code=%h new=%h old=%h required 1 5 5 0",
                     ev_count - start, key_code, digit_new, digit_old);
        end
    endtask

    task automatic press_release(input int r, input int c, input int hold, input int idle);
        exp_code = keymap[r*4+c];
        pressed = 16'h0;
        pressed[r*4+c] = 1'b1;
        steps(hold);
        pressed = 16'h0;
        steps(idle);
    endtask

    task automatic test_back_to_back();
        int start;
        start = ev_count;
        press_release(1, 1, 40, 25);
        press_release(0, 3, 40, 25);
        checks++;
        if (ev_count != start + 2 || key_code !== 4'hA || digit_new !== 4'hA || digit_old !== 4'h5) begin
            failures++;
            $display("FAIL back_to_back events=%0d code=%h new=%h old=%h required 2 A A 5",
                     ev_count - start, key_code, digit_new, digit_old);
        end
    endtask

    task automatic test_short_press();
        int start;
        logic [3:0] n0, o0, c0;
        start = ev_count;
        n0 = digit_new;
        o0 = digit_old;
        for (int i = 0; i < 3; i++) press_release(2, 2, 5, 15);
        checks++;
        if (ev_count != start || digit_new !== n0 || digit_old !== o0) begin
            failures++;
            $display("FAIL short_press events=%0d new=%h old=%h required 0 %h %h",
                     ev_count - start, digit_new, digit_old, n0, o0);
        end
        c0 = cols;
        for (int i = 0; i < 20 && cols === c0; i++) step();
        checks++;
        if (cols === c0) begin
            failures++;
            $display("FAIL short_scan_resume cols stuck at %b", cols);
        end
    endtask

    task automatic test_bounce_release();
        int start;
        start = ev_count;
        exp_code = keymap[3*4+1];
        pressed = 16'h0;
        pressed[3*4+1] = 1'b1;
        wait_event(start, 60, "bounce");
        steps(10);
        pressed = 16'h0;
        steps(3);
        pressed[3*4+1] = 1'b1;
        steps(2);
        pressed = 16'h0;
        check_release_resume(1, "bounce");
        steps(10);
        checks++;
        if (ev_count != start + 1 || key_code !== 4'h0) begin
            failures++;
            $display("FAIL bounce_events events=%0d code=%h required 1 0", ev_count - start, key_code);
        end
    endtask

    task automatic test_held_reset();
        int start;
        start = ev_count;
        exp_code = keymap[0*4+1];
        pressed = 16'h0;
        pressed[0*4+1] = 1'b1;
        wait_event(start, 60, "held_first");
        pressed[2*4+1] = 1'b1;
        steps(20);
        checks++;
        if (ev_count != start + 1) begin
            failures++;
            $display("FAIL held_second_key events=%0d required=1", ev_count - start);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (cols !== 4'b1110 || {key_valid, key_code, digit_new, digit_old} !== 13'h0) begin
            failures++;
            $display("FAIL held_reset cols=%b kv=%b code=%h new=%h old=%h required 1110 0 0 0 0",
                     cols, key_valid, key_code, digit_new, digit_old);
        end
        start = ev_count;
        wait_event(start, 60, "held_redetect");
        steps(20);
        pressed = 16'h0;
        steps(30);
        checks++;
        if (ev_count != start + 1 || key_code !== 4'h2 || digit_new !== 4'h2 || digit_old !== 4'h0) begin
            failures++;
            $display("FAIL held_redetect events=%0d code=%h new=%h old=%h required 1 2 2 0",
                     ev_count - start, key_code, digit_new, digit_old);
        end
    endtask

    task automatic test_priority();
        for (int it = 0; it < 4; it++) begin
            int c, ra, rb, start;
            c  = $urandom_range(3, 0);
            ra = $urandom_range(3, 0);
            rb = (ra + $urandom_range(3, 1)) % 4;
            start = ev_count;
            exp_code = keymap[((ra < rb) ? ra : rb)*4 + c];
            pressed = 16'h0;
            pressed[ra*4+c] = 1'b1;
            pressed[rb*4+c] = 1'b1;
            steps(45);
            pressed = 16'h0;
            steps(25);
            checks++;
            if (ev_count != start + 1 || key_code !== exp_code) begin
                failures++;
                $display("FAIL priority c=%0d rows=%0d,%0d events=%0d code=%h required 1 %h",
                         c, ra, rb, ev_count - start, key_code, exp_code);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int k, start;
            logic [3:0] prev_digit;
            k = $urandom_range(15, 0);
            start = ev_count;
            prev_digit = digit_new;
            press_release(k / 4, k % 4, $urandom_range(70, 40), $urandom_range(35, 25));
            checks++;
            if (ev_count != start + 1 || digit_new !== keymap[k] || digit_old !== prev_digit) begin
                failures++;
                $display("FAIL random key=%0d events=%0d new=%h old=%h required 1 %h %h",
                         k, ev_count - start, digit_new, digit_old, keymap[k], prev_digit);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_short_press();
        test_bounce_release();
        test_held_reset();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
